// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the regfile write port between WB and a queued LU path, with a pending-register scoreboard.
module regfile_wr_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              lu_issue,
  input  logic [ADDR_W-1:0] lu_issue_rd,
  input  logic [ADDR_W-1:0] dec_rs1,
  input  logic [ADDR_W-1:0] dec_rs2,
  input  logic [ADDR_W-1:0] dec_rd,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int NR = 1 << ADDR_W;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [NR-1:0] ONE = NR'(1);

  logic [ADDR_W-1:0] q_rd [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [NR-1:0] pending, set_vec, clr_vec;
  logic rf_lu, push, pop, wb_sel, non_empty;

  assign non_empty = count != '0;
  assign lu_ready  = count != FULL;
  assign push      = lu_valid && lu_ready;
  assign wb_sel    = wb_req && wb_rd != '0;
  assign pop       = !wb_sel && non_empty;
  assign set_vec   = lu_issue && lu_issue_rd != '0 ? ONE << lu_issue_rd : '0;
  // A FIFO-sourced write retires its scoreboard bit on the same edge the array updates.
  assign clr_vec   = rf_we && rf_lu ? ONE << rf_rd : '0;

  always_comb
    stall = starve_cnt == SMAX
         || (dec_rs1 != '0 && pending[dec_rs1])
         || (dec_rs2 != '0 && pending[dec_rs2])
         || (dec_rd != '0 && pending[dec_rd])
         || (lu_issue && pending[lu_issue_rd]);

  always_ff @(posedge clk)
    if (push) begin
      q_rd[wp]   <= lu_rd;
      q_data[wp] <= lu_data;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pending    <= '0;
      rf_we      <= 1'b0;
      rf_lu      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
    end else begin
      wp         <= push ? (wp == LAST ? '0 : wp + 1'b1) : wp;
      rp         <= pop ? (rp == LAST ? '0 : rp + 1'b1) : rp;
      count      <= count + CW'(push) - CW'(pop);
      starve_cnt <= non_empty && wb_sel ? (starve_cnt == SMAX ? SMAX : starve_cnt + 1'b1) : '0;
      pending    <= ((pending & ~clr_vec) | set_vec) & ~ONE;
      rf_we      <= wb_sel || (pop && q_rd[rp] != '0);
      rf_lu      <= !wb_sel && pop;
      rf_rd      <= wb_sel ? wb_rd : pop ? q_rd[rp] : '0;
      rf_wdata   <= wb_sel ? wb_data : pop ? q_data[rp] : '0;
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed scenario tests with hand-computed expectations for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wb_req = 1'b0, lu_valid = 1'b0, lu_issue = 1'b0;
  logic [4:0]  wb_rd = '0, lu_rd = '0, lu_issue_rd = '0, dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic [31:0] wb_data = '0, lu_data = '0;
  logic        lu_ready, stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .wb_req(wb_req), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .stall(stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if ({rf_we, rf_rd, rf_wdata} !== 38'd0) begin failures++; $display("FAIL reset_rf got we=%b rd=%0d data=%h exp 0", rf_we, rf_rd, rf_wdata); end
    checks++; if ({lu_ready, stall} !== 2'b10) begin failures++; $display("FAIL reset_ready_stall got %b exp 10", {lu_ready, stall}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_idle got %b exp 0", rf_we); end
  endtask

  task automatic test_wb_only();
    wb_req = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5A5A5;
    tick();
    checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin failures++; $display("FAIL wb_write got we=%b rd=%0d data=%h exp 1/5/a5a5a5a5", rf_we, rf_rd, rf_wdata); end
    wb_rd = 5'd0;
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL wb_rd0 got we=%b exp 0", rf_we); end
    wb_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    wb_req = 1'b1; wb_rd = 5'd3; wb_data = 32'h30;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h70;
    lu_issue = 1'b1; lu_issue_rd = 5'd7; dec_rs1 = 5'd7;
    tick();
    lu_valid = 1'b0; lu_issue = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cont_pending_set got %b exp 1", stall); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd3, 32'h30 + 32'(i)}) begin failures++; $display("FAIL cont_wb%0d got we=%b rd=%0d data=%h exp 1/3/%h", i, rf_we, rf_rd, rf_wdata, 32'h30 + 32'(i)); end
      wb_data = 32'h31 + 32'(i);
    end
    wb_req = 1'b0;
    tick();
    checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd7, 32'h70}) begin failures++; $display("FAIL cont_lu got we=%b rd=%0d data=%h exp 1/7/70", rf_we, rf_rd, rf_wdata); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cont_pending_hold got %b exp 1", stall); end
    tick();
    checks++; if ({rf_we, stall} !== 2'b00) begin failures++; $display("FAIL cont_pending_clr got we/stall=%b exp 00", {rf_we, stall}); end
    dec_rs1 = 5'd0;
  endtask

  task automatic test_fifo_full();
    wb_req = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hA;
    tick();
    checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL full_one got ready=%b exp 1", lu_ready); end
    lu_rd = 5'd11; lu_data = 32'hB;
    tick();
    checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL full_two got ready=%b exp 0", lu_ready); end
    lu_rd = 5'd12; lu_data = 32'hC;
    tick();
    wb_req = 1'b0;
    #1;
    checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL full_no_pushthru got ready=%b exp 0", lu_ready); end
    tick();
    checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd10, 32'hA}) begin failures++; $display("FAIL full_pop_a got we=%b rd=%0d data=%h exp 1/10/a", rf_we, rf_rd, rf_wdata); end
    tick();
    lu_valid = 1'b0;
    checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd11, 32'hB}) begin failures++; $display("FAIL full_pop_b got we=%b rd=%0d data=%h exp 1/11/b", rf_we, rf_rd, rf_wdata); end
    tick();
    checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd12, 32'hC}) begin failures++; $display("FAIL full_pop_c got we=%b rd=%0d data=%h exp 1/12/c", rf_we, rf_rd, rf_wdata); end
    tick();
    checks++; if ({rf_we, lu_ready} !== 2'b01) begin failures++; $display("FAIL full_drained got we/ready=%b exp 01", {rf_we, lu_ready}); end
  endtask

  task automatic test_starvation();
    wb_req = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'hD;
    tick();
    lu_valid = 1'b0;
    for (int i = 2; i <= 8; i++) tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL starve_before got %b exp 0", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL starve_hit got %b exp 1", stall); end
    tick();
    checks++; if ({stall, rf_rd} !== {1'b1, 5'd4}) begin failures++; $display("FAIL starve_sat got stall=%b rd=%0d exp 1/4", stall, rf_rd); end
    wb_req = 1'b0;
    tick();
    checks++; if ({rf_we, rf_rd, rf_wdata, stall} !== {1'b1, 5'd13, 32'hD, 1'b0}) begin failures++; $display("FAIL starve_drain got we=%b rd=%0d data=%h stall=%b exp 1/13/d/0", rf_we, rf_rd, rf_wdata, stall); end
    tick();
  endtask

  task automatic test_hazard();
    lu_issue = 1'b1; lu_issue_rd = 5'd9;
    tick();
    lu_issue = 1'b0; dec_rs2 = 5'd9;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL haz_raw got %b exp 1", stall); end
    dec_rs2 = 5'd0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL haz_rs0 got %b exp 0", stall); end
    lu_issue = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL haz_waw got %b exp 1", stall); end
    lu_issue = 1'b0; dec_rs2 = 5'd9;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
    checks++; if ({rf_we, stall} !== 2'b01) begin failures++; $display("FAIL haz_queued got we/stall=%b exp 01", {rf_we, stall}); end
    tick();
    checks++; if ({rf_we, rf_rd, stall} !== {1'b1, 5'd9, 1'b1}) begin failures++; $display("FAIL haz_write got we=%b rd=%0d stall=%b exp 1/9/1", rf_we, rf_rd, stall); end
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL haz_release got %b exp 0", stall); end
    dec_rs2 = 5'd0;
  endtask

  task automatic test_lu_zero();
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hDEAD;
    tick();
    lu_valid = 1'b0;
    tick();
    checks++; if ({rf_we, lu_ready} !== 2'b01) begin failures++; $display("FAIL lu_zero got we/ready=%b exp 01", {rf_we, lu_ready}); end
  endtask

  task automatic test_async_reset();
    wb_req = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    lu_valid = 1'b1; lu_rd = 5'd14; lu_data = 32'hE;
    lu_issue = 1'b1; lu_issue_rd = 5'd9;
    tick();
    lu_rd = 5'd15; lu_data = 32'hF; lu_issue = 1'b0;
    tick();
    lu_valid = 1'b0; dec_rs1 = 5'd9;
    #1;
    checks++; if ({rf_we, lu_ready, stall} !== 3'b101) begin failures++; $display("FAIL arst_setup got we/ready/stall=%b exp 101", {rf_we, lu_ready, stall}); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({rf_we, rf_rd, rf_wdata} !== 38'd0) begin failures++; $display("FAIL arst_rf got we=%b rd=%0d data=%h exp 0", rf_we, rf_rd, rf_wdata); end
    checks++; if ({lu_ready, stall} !== 2'b10) begin failures++; $display("FAIL arst_ready_stall got %b exp 10", {lu_ready, stall}); end
    wb_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({rf_we, lu_ready, stall} !== 3'b010) begin failures++; $display("FAIL arst_nostale%0d got we/ready/stall=%b exp 010", i, {rf_we, lu_ready, stall}); end
    end
    dec_rs1 = 5'd0;
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_contention();
    test_fifo_full();
    test_starvation();
    test_hazard();
    test_lu_zero();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
